sonar_echo_responder: RTL and testbench

SONAR_ECHO_RESPONDER -- requirements
Module: sonar_echo_responder

---
 rtl/sonar_echo_responder.sv | 166 ++++++++++++++++
 tb/tb_sonar_echo_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_echo_responder.sv
// HC-SR04 echo emulator: qualifies a trig pulse, waits out the burst, drives echo for the programmed width, then holds off.
// Optional macro SONAR_JITTER_EN adds 0-7 us of LFSR-driven jitter to the echo width.
module sonar_echo_responder #(
  parameter int CLK_PER_US  = 40,
  parameter int MIN_TRIG_US = 10,
  parameter int BURST_US    = 200,
  parameter int TIMEOUT_US  = 38000,
  parameter int HOLDOFF_US  = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trig,
  input  logic [11:0] distance_us,
  output logic        echo,
  output logic        busy,
  output logic        short_trig,
  output logic        done
);

  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] PRESC_MAX    = PW'(CLK_PER_US - 1);
  localparam logic [15:0]   MIN_TRIG_CYC = 16'(MIN_TRIG_US * CLK_PER_US);
  localparam logic [15:0]   BURST_LAST   = 16'(BURST_US - 1);
  localparam logic [15:0]   HOLD_LAST    = 16'(HOLDOFF_US - 1);

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_BURST, S_ECHO, S_HOLDOFF} state_t;

  state_t          r_state;
  logic            r_trig_meta;
  logic            r_trig_sync;
  logic            r_armed;
  logic [15:0]     r_cnt;
  logic [PW-1:0]   r_presc;
  logic [15:0]     r_us;
  logic [15:0]     r_width;
  logic            r_echo;
  logic            r_busy;
  logic            r_short;
  logic            r_done;

  logic            w_trig;
  logic            w_tick;
  logic            w_accept;
  logic [2:0]      w_jit;
  logic [15:0]     w_width_last;

  // Zero distance means "no object"; the sum saturates rather than wraps.
  function automatic logic [15:0] f_width(input logic [11:0] d, input logic [2:0] j);
    logic [15:0] base;
    logic [16:0] sum;
    base = (d == 12'd0) ? 16'(TIMEOUT_US) : {4'd0, d};
    sum  = {1'b0, base} + {14'd0, j};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  assign w_trig       = r_trig_sync;
  assign w_tick       = (r_presc == PRESC_MAX);
  assign w_accept     = (r_state == S_TRIG) && !w_trig && (r_cnt >= MIN_TRIG_CYC);
  assign w_width_last = r_width - 16'd1;

`ifdef SONAR_JITTER_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
    end else if (w_accept) begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_jit = r_lfsr[2:0];
`else
  assign w_jit = 3'd0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_trig_meta <= 1'b0;
      r_trig_sync <= 1'b0;
      r_armed     <= 1'b0;
      r_cnt       <= 16'd0;
      r_presc     <= '0;
      r_us        <= 16'd0;
      r_width     <= 16'd0;
      r_echo      <= 1'b0;
      r_busy      <= 1'b0;
      r_short     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_trig_meta <= trig;
      r_trig_sync <= r_trig_meta;
      r_short     <= 1'b0;
      r_done      <= 1'b0;
      r_presc     <= w_tick ? '0 : r_presc + 1'b1;
      r_us        <= w_tick ? r_us + 16'd1 : r_us;

      case (r_state)
        S_IDLE: begin
          r_presc <= '0;
          r_us    <= 16'd0;
          // A trig still high from the previous cycle must drop before it can re-arm.
          if (!w_trig) begin
            r_armed <= 1'b1;
          end else if (r_armed) begin
            r_state <= S_TRIG;
            r_busy  <= 1'b1;
            r_cnt   <= 16'd1;
          end
        end
        S_TRIG: begin
          if (w_trig) begin
            r_cnt <= (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
          end else if (w_accept) begin
            r_state <= S_BURST;
            r_width <= f_width(distance_us, w_jit);
            r_presc <= '0;
            r_us    <= 16'd0;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_short <= 1'b1;
          end
        end
        S_BURST: begin
          if (w_tick && (r_us == BURST_LAST)) begin
            r_state <= S_ECHO;
            r_echo  <= 1'b1;
            r_presc <= '0;
            r_us    <= 16'd0;
          end
        end
        S_ECHO: begin
          if (w_tick && (r_us == w_width_last)) begin
            r_state <= S_HOLDOFF;
            r_echo  <= 1'b0;
            r_done  <= 1'b1;
            r_presc <= '0;
            r_us    <= 16'd0;
          end
        end
        S_HOLDOFF: begin
          if (w_tick && (r_us == HOLD_LAST)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_armed <= 1'b0;
            r_presc <= '0;
            r_us    <= 16'd0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_echo  <= 1'b0;
        end
      endcase
    end
  end

  assign echo       = r_echo;
  assign busy       = r_busy;
  assign short_trig = r_short;
  assign done       = r_done;

endmodule

// File: tb/tb_sonar_echo_responder.sv
// Directed bench for sonar_echo_responder, run with a scaled-down clock rate and timeout.
module tb_sonar_echo_responder;

  localparam int CPU  = 4;
  localparam int MIN  = 10;
  localparam int BUR  = 200;
  localparam int TMO  = 500;
  localparam int HOLD = 50;

  // trig drop -> meta -> sync -> FSM sees low (3 edges), then the full burst
  localparam int RISE_LAT = 3 + BUR * CPU;
  localparam int HOLD_CYC = HOLD * CPU;

`ifdef SONAR_JITTER_EN
  localparam int JIT_SLACK = 7 * CPU;
`else
  localparam int JIT_SLACK = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        trig;
  logic [11:0] distance_us;
  logic        echo;
  logic        busy;
  logic        short_trig;
  logic        done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int short_cnt = 0;

  sonar_echo_responder #(
    .CLK_PER_US (CPU),
    .MIN_TRIG_US(MIN),
    .BURST_US   (BUR),
    .TIMEOUT_US (TMO),
    .HOLDOFF_US (HOLD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .trig       (trig),
    .distance_us(distance_us),
    .echo       (echo),
    .busy       (busy),
    .short_trig (short_trig),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (short_trig === 1'b1) short_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_trig(input int cyc);
    @(negedge clk);
    trig = 1'b1;
    repeat (cyc) @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic measure_rise(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (echo !== 1'b1 && n < 5000);
  endtask

  task automatic measure_width(output int w);
    w = 1;
    while (w < 200000) begin
      @(negedge clk);
      if (echo !== 1'b1) break;
      w++;
    end
  endtask

  task automatic measure_holdoff(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    trig = 1'b0;
    distance_us = 12'd0;
    repeat (3) @(negedge clk);
    checks++; if (echo !== 1'b0) begin failures++; $display("FAIL reset_echo got=%b exp=0", echo); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (short_trig !== 1'b0) begin failures++; $display("FAIL reset_short got=%b exp=0", short_trig); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic;
    int n, w, h, d0;
    distance_us = 12'd444;
    d0 = done_cnt;
    drive_trig(20 * CPU);
    measure_rise(n);
    checks++; if (n != RISE_LAT) begin failures++; $display("FAIL basic_rise_latency got=%0d exp=%0d", n, RISE_LAT); end
    measure_width(w);
    checks++; if (w < 444 * CPU || w > 444 * CPU + JIT_SLACK) begin failures++; $display("FAIL basic_width got=%0d exp=%0d", w, 444 * CPU); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done_at_fall got=%b exp=1", done); end
    measure_holdoff(h);
    checks++; if (h != HOLD_CYC) begin failures++; $display("FAIL basic_holdoff got=%0d exp=%0d", h, HOLD_CYC); end
    repeat (3) @(negedge clk);
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_short;
    int s0;
    s0 = short_cnt;
    drive_trig(9 * CPU);
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL short_busy_in_trig got=%b exp=1", busy); end
    @(negedge clk);
    checks++; if (short_trig !== 1'b1) begin failures++; $display("FAIL short_pulse got=%b exp=1", short_trig); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL short_busy_drop got=%b exp=0", busy); end
    checks++; if (echo !== 1'b0) begin failures++; $display("FAIL short_echo got=%b exp=0", echo); end
    @(negedge clk);
    checks++; if (short_trig !== 1'b0) begin failures++; $display("FAIL short_one_cycle got=%b exp=0", short_trig); end
    repeat (5) @(negedge clk);
    checks++; if (short_cnt - s0 != 1) begin failures++; $display("FAIL short_count got=%0d exp=1", short_cnt - s0); end
  endtask

  task automatic test_boundary;
    int n, w, h;
    distance_us = 12'd20;
    drive_trig(MIN * CPU - 1);
    repeat (3) @(negedge clk);
    checks++; if (short_trig !== 1'b1) begin failures++; $display("FAIL bound_39_rejected got=%b exp=1", short_trig); end
    repeat (3) @(negedge clk);
    drive_trig(MIN * CPU);
    repeat (3) @(negedge clk);
    checks++; if (short_trig !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL bound_40_accepted short=%b busy=%b exp short=0 busy=1", short_trig, busy); end
    measure_rise(n);
    checks++; if (n != RISE_LAT - 3) begin failures++; $display("FAIL bound_rise got=%0d exp=%0d", n, RISE_LAT - 3); end
    measure_width(w);
    checks++; if (w < 20 * CPU || w > 20 * CPU + JIT_SLACK) begin failures++; $display("FAIL bound_width got=%0d exp=%0d", w, 20 * CPU); end
    measure_holdoff(h);
  endtask

  task automatic test_timeout;
    int n, w, h;
    distance_us = 12'd0;
    drive_trig(20 * CPU);
    measure_rise(n);
    measure_width(w);
    checks++; if (w < TMO * CPU || w > TMO * CPU + JIT_SLACK) begin failures++; $display("FAIL timeout_width got=%0d exp=%0d", w, TMO * CPU); end
    measure_holdoff(h);
  endtask

  task automatic test_latch;
    int n, w, h;
    distance_us = 12'd444;
    drive_trig(20 * CPU);
    repeat (100) @(negedge clk);
    distance_us = 12'd3108;
    measure_rise(n);
    checks++; if (n != RISE_LAT - 100) begin failures++; $display("FAIL latch_rise got=%0d exp=%0d", n, RISE_LAT - 100); end
    measure_width(w);
    checks++; if (w < 444 * CPU || w > 444 * CPU + JIT_SLACK) begin failures++; $display("FAIL latch_width got=%0d exp=%0d", w, 444 * CPU); end
    measure_holdoff(h);
    distance_us = 12'd444;
  endtask

  task automatic test_ignore;
    int n, w, h, d0, seen;
    distance_us = 12'd20;
    d0 = done_cnt;
    drive_trig(20 * CPU);
    measure_rise(n);
    w = 1;
    while (w < 1000) begin
      trig = (w <= 20);
      @(negedge clk);
      if (echo !== 1'b1) break;
      w++;
    end
    checks++; if (w < 20 * CPU || w > 20 * CPU + JIT_SLACK) begin failures++; $display("FAIL ignore_echo_width got=%0d exp=%0d", w, 20 * CPU); end
    h = 0;
    while (busy === 1'b1 && h < 1000) begin
      trig = (h < 20 || h >= 40);
      @(negedge clk);
      h++;
    end
    checks++; if (h != HOLD_CYC) begin failures++; $display("FAIL ignore_holdoff got=%0d exp=%0d", h, HOLD_CYC); end
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL ignore_held_trig busy_cycles=%0d exp=0", seen); end
    trig = 1'b0;
    repeat (10) @(negedge clk);
    trig = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ignore_retrigger got=%b exp=1", busy); end
    repeat (20 * CPU - 4) @(negedge clk);
    trig = 1'b0;
    measure_rise(n);
    measure_width(w);
    measure_holdoff(h);
    repeat (3) @(negedge clk);
    checks++; if (done_cnt - d0 != 2) begin failures++; $display("FAIL ignore_done_count got=%0d exp=2", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_echo;
    int n, d0, seen;
    distance_us = 12'd444;
    drive_trig(20 * CPU);
    measure_rise(n);
    repeat (100 * CPU) @(negedge clk);
    d0 = done_cnt;
    #1 reset = 1'b1;
    #1;
    checks++; if (echo !== 1'b0) begin failures++; $display("FAIL rst_echo_async got=%b exp=0", echo); end
    checks++; if (busy !== 1'b0 || short_trig !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_outputs busy=%b short=%b done=%b exp all 0", busy, short_trig, done); end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (2000) begin
      @(negedge clk);
      if (echo === 1'b1 || busy === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL rst_stays_idle active_cycles=%0d exp=0", seen); end
    checks++; if (done_cnt != d0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", done_cnt - d0); end
  endtask

  initial begin
    reset = 1'b1;
    trig = 1'b0;
    distance_us = 12'd0;
    test_reset();
    test_basic();
    test_short();
    test_boundary();
    test_timeout();
    test_latch();
    test_ignore();
    test_reset_mid_echo();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
